// File: rtl/present_pkg.sv
// Shared state encoding and framing constants for the PRESENT byte-stream front end.
package present_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEY_RX,
        ST_PT_RX,
        ST_LOAD_KEY,
        ST_LOAD_PT,
        ST_WAIT,
        ST_TX
    } state_e;

    localparam logic [7:0] CMD_KEY   = 8'h4B;
    localparam logic [7:0] CMD_PT    = 8'h50;
    localparam logic [3:0] KEY_BYTES = 4'd10;
    localparam logic [3:0] PT_BYTES  = 4'd8;
    localparam int unsigned NR_ROUNDS = 32;

endpackage

// File: rtl/present_byte_ser.sv
// 64-bit to byte serializer, MSB byte first; first byte valid the cycle after load.
// Holds out_data_o stable while out_ready_i is low; last_o flags the 8th transfer.
module present_byte_ser (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        load_i,
    input  logic [63:0] data_i,
    output logic [7:0]  out_data_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic        last_o
);

    logic [63:0] sh_q;
    logic [2:0]  cnt_q;
    logic        vld_q;
    logic        xfer;

    assign xfer        = vld_q && out_ready_i;
    assign last_o      = xfer && (cnt_q == 3'd7);
    assign out_data_o  = sh_q[63:56];
    assign out_valid_o = vld_q;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sh_q  <= '0;
            cnt_q <= '0;
            vld_q <= 1'b0;
        end else if (load_i) begin
            sh_q  <= data_i;
            cnt_q <= '0;
            vld_q <= 1'b1;
        end else if (xfer) begin
            sh_q  <= {sh_q[55:0], 8'h00};
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                vld_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/present_stream_ctrl.sv
// Framed byte-stream front end for present_encoder; ciphertext out 34 cycles after last PT byte.
// in_ready low outside IDLE/RX states (bytes held, never dropped); output obeys out_ready.
// Optional WAIT watchdog enabled by PRESENT_CTRL_TIMEOUT_EN.
module present_stream_ctrl
    import present_pkg::*;
`ifdef PRESENT_CTRL_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 40
)
`endif
(
    input  logic        clk,
    input  logic        n_reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  pl,
    output logic [79:0] in_text,
    input  logic        enc_done,
    input  logic [63:0] enc_ct,
    output logic        busy,
    output logic        err
);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [79:0] text_q, text_d;
    logic [1:0]  pl_q, pl_d;
    logic        in_ready_q, in_ready_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
    logic        in_acc;
    logic        ser_load;
    logic        ser_last;
`ifdef PRESENT_CTRL_TIMEOUT_EN
    logic [5:0]  wdog_q, wdog_d;
`endif

    assign in_acc   = in_valid && in_ready_q;
    assign in_ready = in_ready_q;
    assign pl       = pl_q;
    assign in_text  = text_q;
    assign busy     = busy_q;
    assign err      = err_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        text_d   = text_q;
        pl_d     = 2'b00;
        err_d    = 1'b0;
        ser_load = 1'b0;
`ifdef PRESENT_CTRL_TIMEOUT_EN
        wdog_d   = wdog_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_acc) begin
                    cnt_d = '0;
                    if (in_data == CMD_KEY) begin
                        state_d = ST_KEY_RX;
                    end else if (in_data == CMD_PT) begin
                        state_d = ST_PT_RX;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_KEY_RX: begin
                if (in_acc) begin
                    text_d = {text_q[71:0], in_data};
                    cnt_d  = cnt_q + 4'd1;
                    if (cnt_q == KEY_BYTES - 4'd1) begin
                        state_d = ST_LOAD_KEY;
                        pl_d    = 2'b10;
                    end
                end
            end
            ST_PT_RX: begin
                // Upper 16 bits keep whatever key bytes were last shifted in.
                if (in_acc) begin
                    text_d[63:0] = {text_q[55:0], in_data};
                    cnt_d        = cnt_q + 4'd1;
                    if (cnt_q == PT_BYTES - 4'd1) begin
                        state_d = ST_LOAD_PT;
                        pl_d    = 2'b01;
                    end
                end
            end
            ST_LOAD_KEY: state_d = ST_IDLE;
            ST_LOAD_PT: begin
                state_d = ST_WAIT;
`ifdef PRESENT_CTRL_TIMEOUT_EN
                wdog_d  = '0;
`endif
            end
            ST_WAIT: begin
                // enc_done is not looked at in LOAD_PT, so a stale done cannot be captured.
                if (enc_done) begin
                    ser_load = 1'b1;
                    state_d  = ST_TX;
                end
`ifdef PRESENT_CTRL_TIMEOUT_EN
                else if (wdog_q == 6'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wdog_d = wdog_q + 6'd1;
                end
`endif
            end
            ST_TX: begin
                if (ser_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d = state_d inside {ST_IDLE, ST_KEY_RX, ST_PT_RX};
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            text_q     <= '0;
            pl_q       <= 2'b00;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef PRESENT_CTRL_TIMEOUT_EN
            wdog_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            text_q     <= text_d;
            pl_q       <= pl_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
`ifdef PRESENT_CTRL_TIMEOUT_EN
            wdog_q     <= wdog_d;
`endif
        end
    end

    present_byte_ser u_ser (
        .clk         (clk),
        .n_reset     (n_reset),
        .load_i      (ser_load),
        .data_i      (enc_ct),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .last_o      (ser_last)
    );

endmodule

// File: tb/tb_present_stream_ctrl.sv
// Bench for present_stream_ctrl with a cycle-accurate stand-in for present_encoder.
module tb_present_stream_ctrl;
    import present_pkg::*;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  pl;
    logic [79:0] in_text;
    logic        enc_done;
    logic [63:0] enc_ct;
    logic        busy;
    logic        err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit stall_enc = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    present_stream_ctrl dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pl        (pl),
        .in_text   (in_text),
        .enc_done  (enc_done),
        .enc_ct    (enc_ct),
        .busy      (busy),
        .err       (err)
    );

    // Encoder stand-in: published PRESENT-80 vectors; anything else yields an unrelated value.
    function automatic logic [63:0] cipher(input logic [79:0] k, input logic [63:0] p);
        if (k == '0 && p == '0) return 64'h5579C1387B228445;
        if (k == '1 && p == '0) return 64'hE72C46C0F5945049;
        if (k == '1 && p == '1) return 64'h3333DCD3213210D2;
        if (k == '0 && p == '1) return 64'hA112FFC72F68417B;
        return k[63:0] ^ p ^ 64'h0123456789ABCDEF;
    endfunction

    logic [79:0] m_key;
    logic [63:0] m_ct;
    logic        m_done, m_busy;
    int          m_cnt;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            m_key <= '0; m_ct <= '0; m_done <= 1'b0; m_busy <= 1'b0; m_cnt <= 0;
        end else begin
            if (pl[1]) m_key <= in_text;
            if (pl[0]) begin
                m_done <= 1'b0; m_busy <= 1'b1; m_cnt <= 1;
                m_ct   <= cipher(m_key, in_text[63:0]);
            end else if (m_busy && !stall_enc) begin
                if (m_cnt == NR_ROUNDS - 1) begin
                    m_done <= 1'b1; m_busy <= 1'b0;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end
        end
    end

    assign enc_done = m_done;
    assign enc_ct   = m_done ? m_ct : 64'hDEADBEEFDEADBEEF;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called just after a negedge; returns at the negedge following the accepting edge.
    task automatic send_byte(input logic [7:0] b, output int t);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("in_ready_wait_expired", 0, 1);
        t = cyc;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [79:0] data, input int nbytes, output int t);
        send_byte(cmd, t);
        for (int i = 0; i < nbytes; i++) send_byte(data[8*(nbytes-1-i) +: 8], t);
    endtask

    task automatic recv(input logic [63:0] exp, input bit stall, input int exp_first);
        int n = 0;
        int got = 0;
        int first = -1;
        int bad_stable = 0;
        int bad_ready = 0;
        logic [7:0]  held = '0;
        bit          was_stalled = 1'b0;
        logic [63:0] acc = '0;
        while (got < 8 && n < 600) begin
            out_ready = stall ? ((n % 3) == 0) : 1'b1;
            if (out_valid) begin
                if (first < 0) first = cyc;
                if (in_ready) bad_ready++;
                if (was_stalled && out_data !== held) bad_stable++;
                if (out_ready) begin
                    acc = {acc[55:0], out_data};
                    got++;
                    was_stalled = 1'b0;
                end else begin
                    was_stalled = 1'b1;
                    held = out_data;
                end
            end
            @(negedge clk);
            n++;
        end
        out_ready = 1'b0;
        chk("first_out_valid_cycle", first, exp_first);
        chk("out_byte_count", got, 8);
        for (int i = 0; i < 8; i++) chk($sformatf("ct_byte%0d", i), acc[63-8*i -: 8], exp[63-8*i -: 8]);
        chk("out_data_stable_when_stalled", bad_stable, 0);
        chk("in_ready_low_during_tx", bad_ready, 0);
        chk("idle_after_tx_busy", busy, 0);
        chk("idle_after_tx_in_ready", in_ready, 1);
        chk("no_extra_out_valid", out_valid, 0);
    endtask

    typedef struct {
        bit          load_key;
        logic [79:0] key;
        logic [63:0] pt;
        logic [63:0] exp_ct;
        bit          stall;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v);
        int t;
        if (v.load_key) begin
            send_frame(CMD_KEY, v.key, 10, t);
            chk("key_pl_load", pl, 2'b10);
            chk("key_busy", busy, 1);
            @(negedge clk);
            chk("key_pl_clear", pl, 2'b00);
            chk("key_back_idle", busy, 0);
        end
        send_frame(CMD_PT, {16'h0, v.pt}, 8, t);
        chk("pt_pl_load", pl, 2'b01);
        chk("pt_load_in_ready", in_ready, 0);
        recv(v.exp_ct, v.stall, t + 34);
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t;
        vecs[0] = '{1'b0, 80'h0,  64'h0,  64'h5579C1387B228445, 1'b0};
        vecs[1] = '{1'b1, '1,     64'h0,  64'hE72C46C0F5945049, 1'b0};
        vecs[2] = '{1'b0, 80'h0,  '1,     64'h3333DCD3213210D2, 1'b0};
        vecs[3] = '{1'b0, 80'h0,  64'h0,  64'hE72C46C0F5945049, 1'b1};
        vecs[4] = '{1'b0, 80'h0,  '1,     64'h3333DCD3213210D2, 1'b0};
        vecs[5] = '{1'b1, 80'h0,  '1,     64'hA112FFC72F68417B, 1'b0};

        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_pl", pl, 0);
        chk("rst_in_text", in_text, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        n_reset = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        send_byte(8'h11, t);
        chk("bad_cmd_err_pulse", err, 1);
        chk("bad_cmd_stays_idle", busy, 0);
        @(negedge clk);
        chk("bad_cmd_err_one_cycle", err, 0);
        chk("bad_cmd_in_ready", in_ready, 1);
        run_vec(vecs[4]);

        send_byte(CMD_PT, t);
        for (int i = 0; i < 4; i++) send_byte(8'h5A, t);
        chk("mid_frame_busy", busy, 1);
        n_reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_in_text", in_text, 0);
        n_reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_release_err", err, 0);
        chk("mid_rst_release_ready", in_ready, 1);
        run_vec(vecs[5]);

`ifdef PRESENT_CTRL_TIMEOUT_EN
        begin
            int n = 0;
            int err_at = -1;
            int saw_valid = 0;
            stall_enc = 1'b1;
            send_frame(CMD_PT, 80'h0, 8, t);
            while (err_at < 0 && n < 100) begin
                if (err) err_at = cyc;
                if (out_valid) saw_valid++;
                @(negedge clk);
                n++;
            end
            chk("timeout_err_cycle", err_at, t + 42);
            chk("timeout_no_output", saw_valid, 0);
            chk("timeout_back_idle", busy, 0);
            stall_enc = 1'b0;
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
